// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_pkg
//  Description : Shared types and constants for the neural-network inference
//                sequencer. It holds the state encoding, the pass-select codes
//                for ctrl_w_b_data_neuron and the layer geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    localparam int NEURON_COUNT  = 10;
    localparam int H_NODE_NUMBER = 20;
    localparam int O_NODE_NUMBER = 10;

    localparam logic [1:0] CTRL_H1  = 2'b00;
    localparam logic [1:0] CTRL_H2  = 2'b01;
    localparam logic [1:0] CTRL_OUT = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_H1_START = 4'd1,
        ST_H1_WAIT  = 4'd2,
        ST_H1_LOAD  = 4'd3,
        ST_H2_START = 4'd4,
        ST_H2_WAIT  = 4'd5,
        ST_H2_LOAD  = 4'd6,
        ST_O_START  = 4'd7,
        ST_O_WAIT   = 4'd8,
        ST_ARGMAX   = 4'd9,
        ST_NEXT     = 4'd10,
        ST_DONE     = 4'd11
    } state_t;

    // Pass select is a pure function of the state, so it cannot change
    // partway through a phase.
    function automatic logic [1:0] pass_ctrl(input state_t s);
        logic [1:0] c;
        c = CTRL_H1;
        case (s)
            ST_H2_START, ST_H2_WAIT, ST_H2_LOAD:         c = CTRL_H2;
            ST_O_START, ST_O_WAIT, ST_ARGMAX:            c = CTRL_OUT;
            default:                                     c = CTRL_H1;
        endcase
        return c;
    endfunction

endpackage : nn_pkg
`default_nettype wire

// File: rtl/nn_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : nn_sequencer_if
//  Description : Control/status bundle between the sequencer (master) and the
//                datapath / host side (slave).
//  Signals     : start, ready[9:0], max_index[4:0], label[4:0]   -> sequencer
//                startNeurons, ctrl_w_b_data_neuron[1:0], ld_regs1, ld_regs2,
//                enMax, dataGroupNumber[10:0], busy, done, err,
//                result_valid, result_index[4:0]                 <- sequencer
//                correct_count[10:0] only with NN_ACCURACY_COUNT_EN defined
//  Revision    : 1.0 - initial release
// ============================================================================
interface nn_sequencer_if
    import nn_pkg::*;
();
    logic                    start;
    logic [NEURON_COUNT-1:0] ready;
    logic [4:0]              max_index;
    logic [4:0]              label;

    logic                    startNeurons;
    logic [1:0]              ctrl_w_b_data_neuron;
    logic                    ld_regs1;
    logic                    ld_regs2;
    logic                    enMax;
    logic [10:0]             dataGroupNumber;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic                    result_valid;
    logic [4:0]              result_index;
`ifdef NN_ACCURACY_COUNT_EN
    logic [10:0]             correct_count;
`endif

    modport master (
        input  start, ready, max_index, label,
`ifdef NN_ACCURACY_COUNT_EN
        output correct_count,
`endif
        output startNeurons, ctrl_w_b_data_neuron, ld_regs1, ld_regs2, enMax,
               dataGroupNumber, busy, done, err, result_valid, result_index
    );

    modport slave (
        output start, ready, max_index, label,
`ifdef NN_ACCURACY_COUNT_EN
        input  correct_count,
`endif
        input  startNeurons, ctrl_w_b_data_neuron, ld_regs1, ld_regs2, enMax,
               dataGroupNumber, busy, done, err, result_valid, result_index
    );

endinterface : nn_sequencer_if
`default_nettype wire

// File: rtl/nn_sequencer_ready_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : nn_ready_watchdog
//  Description : Wait-cycle counter shared by the three WAIT states. It masks
//                ready in the first wait cycle (bits may still be left over
//                from the previous pass) and flags a timeout in the wait
//                cycle numbered READY_TIMEOUT when ready is still not seen.
//  Ports       : clk, rst_n       clock, async active-low reset
//                clr_i            restart the count (START states)
//                en_i             a WAIT state is active
//                ready_i[9:0]     neuron ready bits
//                ready_ok_o       all ready, outside the masked first cycle
//                timeout_o        last allowed wait cycle without ready
//  Revision    : 1.0 - initial release
// ============================================================================
module nn_ready_watchdog
    import nn_pkg::*;
#(
    parameter int READY_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic [NEURON_COUNT-1:0] ready_i,
    output logic                    ready_ok_o,
    output logic                    timeout_o
);

    localparam int             CNT_W    = $clog2(READY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READY_TIMEOUT - 1);

    // Holds (wait cycle number - 1) while a WAIT state is active.
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST_CNT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ready_ok_o = en_i && (cnt_q != '0) && (&ready_i);
    assign timeout_o  = en_i && (cnt_q == LAST_CNT) && !ready_ok_o;

endmodule : nn_ready_watchdog
`default_nettype wire

// File: rtl/nn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : nn_sequencer
//  Description : Control FSM for the 62-20-10 inference datapath. Per sample it
//                runs hidden pass 0-9, hidden pass 10-19 and the output pass,
//                strobes ArgMax, captures the class index and moves on to the
//                next data group until SAMPLE_COUNT groups are classified.
//  Ports       : clk              rising-edge clock
//                rst_n            asynchronous active-low reset
//                bus (master)     control/status bundle, see nn_sequencer_if
//  Parameters  : SAMPLE_COUNT     data groups per run (1..2048)
//                READY_TIMEOUT    wait cycles allowed per pass
//  Option      : NN_ACCURACY_COUNT_EN adds correct_count (matches vs label)
//  Revision    : 1.0 - initial release
// ============================================================================
module nn_sequencer
    import nn_pkg::*;
#(
    parameter int SAMPLE_COUNT  = 750,
    parameter int READY_TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    nn_sequencer_if.master bus
);

    localparam logic [10:0] LAST_GROUP = 11'(SAMPLE_COUNT - 1);

    state_t      state_q, state_d;
    logic [10:0] group_q, group_d;
    logic        err_q, err_d;
    logic [4:0]  result_q, result_d;

    logic        wd_clr;
    logic        wd_en;
    logic        wd_ready_ok;
    logic        wd_timeout;
    logic        accept;

    nn_ready_watchdog #(
        .READY_TIMEOUT (READY_TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (wd_clr),
        .en_i       (wd_en),
        .ready_i    (bus.ready),
        .ready_ok_o (wd_ready_ok),
        .timeout_o  (wd_timeout)
    );

    assign accept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.start;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wd_clr  = 1'b0;
        wd_en   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) state_d = ST_H1_START;
            end
            ST_H1_START: begin
                wd_clr  = 1'b1;
                state_d = ST_H1_WAIT;
            end
            ST_H1_WAIT: begin
                wd_en = 1'b1;
                if (wd_ready_ok)     state_d = ST_H1_LOAD;
                else if (wd_timeout) state_d = ST_DONE;
            end
            ST_H1_LOAD:  state_d = ST_H2_START;
            ST_H2_START: begin
                wd_clr  = 1'b1;
                state_d = ST_H2_WAIT;
            end
            ST_H2_WAIT: begin
                wd_en = 1'b1;
                if (wd_ready_ok)     state_d = ST_H2_LOAD;
                else if (wd_timeout) state_d = ST_DONE;
            end
            ST_H2_LOAD:  state_d = ST_O_START;
            ST_O_START: begin
                wd_clr  = 1'b1;
                state_d = ST_O_WAIT;
            end
            ST_O_WAIT: begin
                wd_en = 1'b1;
                if (wd_ready_ok)     state_d = ST_ARGMAX;
                else if (wd_timeout) state_d = ST_DONE;
            end
            ST_ARGMAX:   state_d = ST_NEXT;
            ST_NEXT: begin
                state_d = (group_q == LAST_GROUP) ? ST_DONE : ST_H1_START;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers next values
    // ------------------------------------------------------------------
    always_comb begin
        group_d  = group_q;
        err_d    = err_q;
        result_d = result_q;
        if (accept) begin
            group_d = '0;
            err_d   = 1'b0;
        end else begin
            if ((state_q == ST_NEXT) && (group_q != LAST_GROUP)) begin
                group_d = group_q + 11'd1;
            end
            if (wd_timeout) begin
                err_d = 1'b1;
            end
            if (state_q == ST_ARGMAX) begin
                result_d = bus.max_index;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            group_q  <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            group_q  <= group_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

`ifdef NN_ACCURACY_COUNT_EN
    logic [10:0] correct_q, correct_d;

    always_comb begin
        correct_d = correct_q;
        if (accept) begin
            correct_d = '0;
        end else if ((state_q == ST_ARGMAX) && (bus.max_index == bus.label)
                     && (correct_q != 11'h7FF)) begin
            correct_d = correct_q + 11'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            correct_q <= '0;
        end else begin
            correct_q <= correct_d;
        end
    end

    assign bus.correct_count = correct_q;
`else
    logic label_unused;
    assign label_unused = ^bus.label;
`endif

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    assign bus.startNeurons = (state_q == ST_H1_START) || (state_q == ST_H2_START)
                           || (state_q == ST_O_START);
    assign bus.ld_regs1             = (state_q == ST_H1_LOAD);
    assign bus.ld_regs2             = (state_q == ST_H2_LOAD);
    assign bus.enMax                = (state_q == ST_ARGMAX);
    assign bus.result_valid         = (state_q == ST_NEXT);
    assign bus.done                 = (state_q == ST_DONE);
    assign bus.busy                 = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.ctrl_w_b_data_neuron = pass_ctrl(state_q);
    assign bus.dataGroupNumber      = group_q;
    assign bus.err                  = err_q;
    assign bus.result_index         = result_q;

endmodule : nn_sequencer
`default_nettype wire

// File: tb/tb_nn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nn_sequencer
//  Description : Self-checking bench for nn_sequencer (SAMPLE_COUNT=2,
//                READY_TIMEOUT=8). A schedule model expands each run into the
//                per-cycle output vector it must produce; one process compares
//                the DUT against it on every negative edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_sequencer;
    import nn_pkg::*;

    localparam int SC = 2;
    localparam int TO = 8;

    typedef struct packed {
        logic        sn;
        logic [1:0]  ctrl;
        logic        ld1;
        logic        ld2;
        logic        en;
        logic        busy;
        logic        done;
        logic        err;
        logic        rv;
        logic [10:0] dgn;
        logic [4:0]  ri;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nn_sequencer_if bus ();

    nn_sequencer #(
        .SAMPLE_COUNT  (SC),
        .READY_TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    // model state carried between runs
    logic        m_done = 1'b0;
    logic        m_err  = 1'b0;
    logic [10:0] m_dgn  = '0;
    logic [4:0]  m_ri   = '0;

    int         mode = 0;      // 0: ready 3 cycles after start, 1: always 3FF, 2: 1FF in H2
    logic [4:0] mi   = 5'd0;   // max_index presented during enMax
    int         sn_cnt = 0, ld2_cnt = 0, rv_cnt = 0;
    logic [4:0] lab_tab [2] = '{5'd7, 5'd2};

    task automatic check(input string name, input int got, input int expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, expv);
        end
    endtask

    function automatic void push(input logic sn, input logic [1:0] c, input logic l1,
                                 input logic l2, input logic en, input logic b,
                                 input logic rv);
        exp_t e;
        e = {sn, c, l1, l2, en, b, m_done, m_err, rv, m_dgn, m_ri};
        q.push_back(e);
    endfunction

    // Expand one run: the start cycle, then per sample three passes of
    // START + k waits, two loads, ArgMax, Next; a timeout in pass to_pass
    // ends the run after TO waits.
    function automatic void gen(input int k, input int to_pass);
        logic [1:0] c;
        push(0, 2'b00, 0, 0, 0, 0, 0);
        m_done = 1'b0;
        m_err  = 1'b0;
        for (int s = 0; s < SC; s++) begin
            m_dgn = 11'(s);
            for (int j = 1; j <= 3; j++) begin
                c = (j == 1) ? 2'b00 : (j == 2) ? 2'b01 : 2'b10;
                push(1, c, 0, 0, 0, 1, 0);
                if (j == to_pass) begin
                    for (int w = 0; w < TO; w++) push(0, c, 0, 0, 0, 1, 0);
                    m_err  = 1'b1;
                    m_done = 1'b1;
                    push(0, 2'b00, 0, 0, 0, 0, 0);
                    return;
                end
                for (int w = 0; w < k; w++) push(0, c, 0, 0, 0, 1, 0);
                if (j == 1)      push(0, 2'b00, 1, 0, 0, 1, 0);
                else if (j == 2) push(0, 2'b01, 0, 1, 0, 1, 0);
                else             push(0, 2'b10, 0, 0, 1, 1, 0);
            end
            m_ri = mi;
            push(0, 2'b00, 0, 0, 0, 1, 1);
        end
        m_done = 1'b1;
        push(0, 2'b00, 0, 0, 0, 0, 0);
    endfunction

    // Neuron / ArgMax / label stand-in
    initial begin
        int dly;
        dly = 0;
        bus.ready     = '0;
        bus.max_index = 5'd31;
        bus.label     = 5'd0;
        forever begin
            @(negedge clk);
            if (bus.startNeurons) dly = 0;
            else if (dly < 15)    dly++;
            case (mode)
                0:       bus.ready = (dly >= 3) ? 10'h3FF : 10'h000;
                1:       bus.ready = 10'h3FF;
                default: bus.ready = (bus.ctrl_w_b_data_neuron == CTRL_H2) ? 10'h1FF : 10'h3FF;
            endcase
            bus.max_index = bus.enMax ? mi : 5'd31;
            bus.label     = lab_tab[bus.dataGroupNumber[0]];
        end
    end

    // Per-cycle compare against the model
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {bus.startNeurons, bus.ctrl_w_b_data_neuron, bus.ld_regs1, bus.ld_regs2,
                     bus.enMax, bus.busy, bus.done, bus.err, bus.result_valid,
                     bus.dataGroupNumber, bus.result_index};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL cycle t=%0t got=%h exp=%h (sn,ctrl,ld1,ld2,en,busy,done,err,rv,dgn,ri)",
                             $time, a, e);
                end
                sn_cnt  += int'(bus.startNeurons);
                ld2_cnt += int'(bus.ld_regs2);
                rv_cnt  += int'(bus.result_valid);
            end
        end
    end

    task automatic launch(input int k, input int to_pass);
        @(posedge clk); #1;
        bus.start = 1'b1;
        sn_cnt = 0; ld2_cnt = 0; rv_cnt = 0;
        gen(k, to_pass);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (q.size() > 0 && c < 300) begin
            @(negedge clk); #1;
            c++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout got=%0d exp=0 records left", q.size());
            q.delete();
        end
    endtask

    initial begin
        int c, first1;
        bus.start = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {bus.startNeurons, bus.ctrl_w_b_data_neuron, bus.ld_regs1,
              bus.ld_regs2, bus.enMax, bus.busy, bus.done, bus.err, bus.result_valid}, 0);
        check("rst_dgn", bus.dataGroupNumber, 0);
        check("rst_result_index", bus.result_index, 0);
        rst_n = 1'b1;

        // run 1: ready 3 cycles after startNeurons, k=3 -> 16 cycles per sample
        mode = 0; mi = 5'd3;
        launch(3, 0);
        c = 0; first1 = -1;
        while (!bus.done && c < 100) begin
            @(posedge clk); #1;
            c++;
            if (bus.dataGroupNumber == 11'd1 && first1 < 0) first1 = c;
        end
        check("done_latency", c, 32);
        check("dgn_step_cycle", first1, 16);
        drain();
        check("run1_result_index", bus.result_index, 3);
        check("run1_start_pulses", sn_cnt, 6);

        // run 2: ready held high, first wait cycle must be ignored (k=2)
        mode = 1; mi = 5'd9;
        launch(2, 0);
        drain();
        check("run2_start_pulses", sn_cnt, 6);
        check("run2_result_index", bus.result_index, 9);

        // run 3: ready stuck at 1FF during hidden pass 2 -> timeout
        mode = 2;
        launch(2, 2);
        drain();
        check("to_err", bus.err, 1);
        check("to_done", bus.done, 1);
        check("to_ld_regs2", ld2_cnt, 0);

        // run 4: max_index 7, restart clears err, start while busy ignored
        mode = 0; mi = 5'd7;
        launch(3, 0);
        check("err_cleared", bus.err, 0);
        repeat (5) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        drain();
        check("run4_result_index", bus.result_index, 7);
        check("run4_result_valid_pulses", rv_cnt, SC);
`ifdef NN_ACCURACY_COUNT_EN
        check("correct_count", bus.correct_count, 1);
`endif

        // run 5: asynchronous reset in O_WAIT of sample 1
        mode = 0; mi = 5'd5;
        launch(3, 0);
        repeat (28) @(posedge clk);
        #1;
        check("pre_rst_ctrl", bus.ctrl_w_b_data_neuron, 2);
        check("pre_rst_dgn", bus.dataGroupNumber, 1);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        check("async_rst_outputs", {bus.startNeurons, bus.ctrl_w_b_data_neuron, bus.ld_regs1,
              bus.ld_regs2, bus.enMax, bus.busy, bus.done, bus.err, bus.result_valid,
              bus.dataGroupNumber, bus.result_index}, 0);
        m_done = 1'b0; m_err = 1'b0; m_dgn = '0; m_ri = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // run 6: fresh start after reset resumes at group 0
        mi = 5'd2;
        launch(3, 0);
        check("restart_dgn", bus.dataGroupNumber, 0);
        drain();
        check("run6_done", bus.done, 1);
        check("run6_last_dgn", bus.dataGroupNumber, SC - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_nn_sequencer
`default_nettype wire
